// File: rtl/phy_emu_pkg.sv
// Shared definitions for the PHY emulator: control characters, speed
// encodings, capture state enum and the lane padding helper.
package phy_emu_pkg;

    localparam logic [7:0] IDLE_CH  = 8'h07;
    localparam logic [7:0] START_CH = 8'hFB;
    localparam logic [7:0] TERM_CH  = 8'hFD;

    localparam logic [1:0] SPD_NONE = 2'b00;
    localparam logic [1:0] SPD_1G   = 2'b01;
    localparam logic [1:0] SPD_100M = 2'b10;
    localparam logic [1:0] SPD_10M  = 2'b11;

    localparam int unsigned DEF_DIV_100M = 10;
    localparam int unsigned DEF_DIV_10M  = 100;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } cap_state_t;

    // Replace every lane at or above first_pad with IDLE_CH/ctrl=1.
    // first_pad = 8 leaves the word untouched. Result is {ctrl, data}.
    function automatic logic [71:0] pad_word(input logic [63:0] d,
                                             input logic [7:0]  c,
                                             input logic [3:0]  first_pad);
        logic [63:0] pd;
        logic [7:0]  pc;
        pd = d;
        pc = c;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= first_pad) begin
                pd[i*8 +: 8] = IDLE_CH;
                pc[i]        = 1'b1;
            end else begin
                pd[i*8 +: 8] = d[i*8 +: 8];
                pc[i]        = c[i];
            end
        end
        return {pc, pd};
    endfunction

endpackage

// File: rtl/phy_emu_byte_pace.sv
// Byte-sample strobe generator. After a restart at cycle t it strobes at
// t + k*N + H for k >= 1, where N is the clocks per byte and H the mid-byte
// offset for the speed latched at restart. At 1G it strobes every cycle.
module phy_emu_byte_pace
    import phy_emu_pkg::*;
#(
    parameter int unsigned DIV_100M = DEF_DIV_100M,
    parameter int unsigned DIV_10M  = DEF_DIV_10M
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fmac_speed,
    input  logic       restart,
    output logic       strobe
);

    logic [6:0] div_s;
    logic [6:0] half_s;
    logic [6:0] div_r;
    logic [6:0] half_r;
    logic [6:0] cnt_r;
    logic       first_r;
    logic [6:0] div_nxt_s;
    logic [6:0] half_nxt_s;
    logic [6:0] cnt_nxt_s;
    logic       first_nxt_s;

    // Decode the period (N-1) and mid-byte offset for the requested speed.
    always_comb begin
        div_s  = 7'd0;
        half_s = 7'd0;
        case (fmac_speed)
            SPD_1G: begin
                div_s  = 7'd0;
                half_s = 7'd0;
            end
            SPD_100M: begin
                div_s  = 7'(DIV_100M - 1);
                half_s = 7'(DIV_100M / 2);
            end
            SPD_10M: begin
                div_s  = 7'(DIV_10M - 1);
                half_s = 7'(DIV_10M / 2);
            end
            default: begin
                div_s  = 7'd0;
                half_s = 7'd0;
            end
        endcase
    end

    // Next-state of the phase counter; cnt tracks (cycle - t) mod N and
    // first marks that the first full byte period has elapsed.
    always_comb begin
        div_nxt_s   = div_r;
        half_nxt_s  = half_r;
        cnt_nxt_s   = cnt_r;
        first_nxt_s = first_r;
        if (restart) begin
            div_nxt_s   = div_s;
            half_nxt_s  = half_s;
            cnt_nxt_s   = (div_s == 7'd0) ? 7'd0 : 7'd1;
            first_nxt_s = (div_s == 7'd0);
        end else if (cnt_r == div_r) begin
            cnt_nxt_s   = 7'd0;
            first_nxt_s = 1'b1;
        end else begin
            cnt_nxt_s   = cnt_r + 7'd1;
            first_nxt_s = first_r;
        end
    end

    // Register the counter state and a look-ahead strobe so the strobe
    // is high exactly in the sample cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= 7'd0;
            half_r  <= 7'd0;
            cnt_r   <= 7'd0;
            first_r <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            div_r   <= div_nxt_s;
            half_r  <= half_nxt_s;
            cnt_r   <= cnt_nxt_s;
            first_r <= first_nxt_s;
            strobe  <= first_nxt_s && (cnt_nxt_s == half_nxt_s);
        end
    end

endmodule

// File: rtl/tx_gmii_cap3_8b.sv
// GMII capture: samples the MAC transmit byte stream at the selected pacing
// and reassembles it into 64-bit XGMII-style words with 8-bit control masks.
module tx_gmii_cap3_8b
    import phy_emu_pkg::*;
#(
    parameter int unsigned DIV_100M = DEF_DIV_100M,
    parameter int unsigned DIV_10M  = DEF_DIV_10M
) (
    input  logic        xaui_clk,
    input  logic        reset,
    input  logic [1:0]  fmac_speed,
    input  logic        cap_en,
    input  logic [7:0]  data_in,
    input  logic        ctrl_in,
    output logic [63:0] rxd_out,
    output logic [7:0]  rxc_out,
    output logic        word_vld,
    output logic        pkt_end,
    output logic        pkt_err,
    output logic [15:0] pkt_cnt
);

    cap_state_t  state_r;
    logic [2:0]  lane_r;
    logic [1:0]  spd_r;
    logic [63:0] buf_d_r;
    logic [7:0]  buf_c_r;

    logic        start_s;
    logic        strobe_s;
    logic        is_term_s;
    logic        is_trunc_s;
    logic [63:0] wr_d_s;
    logic [7:0]  wr_c_s;
    logic [71:0] end_word_s;
    logic [71:0] abort_word_s;

    phy_emu_byte_pace #(
        .DIV_100M (DIV_100M),
        .DIV_10M  (DIV_10M)
    ) u_pace (
        .clk        (xaui_clk),
        .rst        (reset),
        .fmac_speed (fmac_speed),
        .restart    (start_s),
        .strobe     (strobe_s)
    );

    // Decode start and end-of-packet characters on the incoming byte.
    always_comb begin
        start_s    = (state_r == IDLE) && cap_en && ctrl_in &&
                     (data_in == START_CH) && (fmac_speed != SPD_NONE);
        is_term_s  = ctrl_in && (data_in == TERM_CH);
        is_trunc_s = ctrl_in && (data_in == IDLE_CH);
    end

    // Word under construction with the current byte merged into its lane,
    // plus the padded forms used to close a packet normally or on abort.
    always_comb begin
        wr_d_s = buf_d_r;
        wr_c_s = buf_c_r;
        wr_d_s[{lane_r, 3'b000} +: 8] = data_in;
        wr_c_s[lane_r]                = ctrl_in;
        end_word_s   = pad_word(wr_d_s, wr_c_s, {1'b0, lane_r} + 4'd1);
        abort_word_s = pad_word(buf_d_r, buf_c_r, {1'b0, lane_r});
    end

    // Capture state machine with registered word outputs.
    always_ff @(posedge xaui_clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            lane_r   <= 3'd0;
            spd_r    <= SPD_NONE;
            buf_d_r  <= 64'h0707070707070707;
            buf_c_r  <= 8'hFF;
            rxd_out  <= 64'h0707070707070707;
            rxc_out  <= 8'hFF;
            word_vld <= 1'b0;
            pkt_end  <= 1'b0;
            pkt_err  <= 1'b0;
            pkt_cnt  <= 16'd0;
        end else begin
            word_vld <= 1'b0;
            pkt_end  <= 1'b0;
            pkt_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        buf_d_r[7:0] <= START_CH;
                        buf_c_r[0]   <= 1'b1;
                        lane_r       <= 3'd1;
                        spd_r        <= fmac_speed;
                        state_r      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (fmac_speed != spd_r) begin
                        // Speed changed under a packet: flush what we have.
                        {rxc_out, rxd_out} <= abort_word_s;
                        word_vld <= 1'b1;
                        pkt_end  <= 1'b1;
                        pkt_err  <= 1'b1;
                        pkt_cnt  <= pkt_cnt + 16'd1;
                        lane_r   <= 3'd0;
                        state_r  <= IDLE;
                    end else if (strobe_s) begin
                        if (is_term_s || is_trunc_s) begin
                            {rxc_out, rxd_out} <= end_word_s;
                            word_vld <= 1'b1;
                            pkt_end  <= 1'b1;
                            pkt_err  <= is_trunc_s;
                            pkt_cnt  <= pkt_cnt + 16'd1;
                            lane_r   <= 3'd0;
                            state_r  <= IDLE;
                        end else if (lane_r == 3'd7) begin
                            rxd_out  <= wr_d_s;
                            rxc_out  <= wr_c_s;
                            buf_d_r  <= wr_d_s;
                            buf_c_r  <= wr_c_s;
                            word_vld <= 1'b1;
                            lane_r   <= 3'd0;
                        end else begin
                            buf_d_r  <= wr_d_s;
                            buf_c_r  <= wr_c_s;
                            lane_r   <= lane_r + 3'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    lane_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/tx_gmii_cap3_8b.md
Name: tx_gmii_cap3_8b

Overview:
- Capture side of the PHY emulator: samples the 8-bit GMII-style byte stream (data/ctrl) driven by the MAC transmit path.
- Reassembles the byte stream into 64-bit XGMII-style words (lane 0 = bits [7:0]) with 8-bit control masks, using the same 8-lane convention as the receive-side generator.
- Supports 1G/100M/10M byte pacing, selected by fmac_speed.
- Feeds a testbench scoreboard or capture RAM.

Parameters:
- IDLE_CH, 8'h07, idle control character
- START_CH, 8'hFB, start control character (lane 0 of first word)
- TERM_CH, 8'hFD, terminate control character
- DIV_100M, 10, xaui_clk cycles per byte at 100M
- DIV_10M, 100, xaui_clk cycles per byte at 10M

Ports:
- xaui_clk, input, 1, sole clock
- reset, input, 1, asynchronous, active-high reset
- fmac_speed, input, 2, 01=1G, 10=100M, 11=10M, 00=reserved (block holds IDLE)
- cap_en, input, 1, capture enable; when 0, no new packet start is accepted
- data_in, input, 8, GMII byte from MAC TX
- ctrl_in, input, 1, control flag for data_in
- rxd_out, output, 64, assembled data word
- rxc_out, output, 8, assembled control mask (bit n = lane n)
- word_vld, output, 1, one-cycle strobe: rxd_out/rxc_out valid
- pkt_end, output, 1, asserted with word_vld on the last word of a packet
- pkt_err, output, 1, asserted with pkt_end when the packet was truncated
- pkt_cnt, output, 16, packets completed since reset (wraps at 16'hFFFF to 0)

Behaviour:
- Reset (async assert, sync release) drives the outputs and internal state as follows:
  - rxd_out = 64'h0707070707070707, rxc_out = 8'hFF
  - word_vld = pkt_end = pkt_err = 0, pkt_cnt = 0
  - state = IDLE; lane index = 0; pacing counter = 0
- Byte strobe (pacing):
  - Let N = 1 (1G), DIV_100M (100M) or DIV_10M (10M), and H = 0, 5 or 50 respectively.
  - Start detected at cycle t: in IDLE, with cap_en=1, ctrl_in=1 and data_in=START_CH.
  - Byte k≥1 is sampled at cycle t + k*N + H (mid-byte at the low speeds).
  - At 1G, every cycle after detection is a sample.
- States:
  - IDLE:
    - On start: place START_CH/ctrl=1 in lane 0, lane index := 1, go to COLLECT.
    - All other inputs are ignored.
  - COLLECT: on each sample, write data_in/ctrl_in into the current lane, then:
    - Lane 7 written and byte not TERM_CH: register the word, pulse word_vld next cycle, lane index := 0.
    - ctrl_in=1 and data_in=TERM_CH: write it into its lane; fill the remaining higher lanes with IDLE_CH/ctrl=1; emit the word with word_vld=1 and pkt_end=1; pkt_cnt += 1; go to IDLE.
    - ctrl_in=1 and data_in=IDLE_CH (truncation): handle exactly as TERM_CH, but write IDLE_CH in that lane and also set pkt_err=1.
    - Any other ctrl_in=1 byte: stored as-is, no state change.
- Latency: word_vld is asserted in the cycle after the sample that completed the word.
  - Between word_vld pulses, rxd_out/rxc_out hold their last value.
- Boundary conditions:
  - TERM_CH in lane 0 of a new word: emit an all-control word FD,07×7 with rxc_out=8'hFF.
  - A start character while in COLLECT is stored as data; it is not a restart.
  - fmac_speed change while in COLLECT: abort; emit the partial word padded with IDLE_CH, with pkt_end=pkt_err=1; pkt_cnt += 1; go to IDLE.
  - fmac_speed change while in IDLE: takes effect on the next start.
  - cap_en deasserted mid-packet: the current packet completes normally.
  - fmac_speed=00: stay in IDLE; never detect a start.
  - Reset mid-packet: partial data is discarded, with no word_vld.
- Widths:
  - Pacing counter is 7 bits.
  - Lane index is 3 bits and wraps 7 → 0.
  - pkt_cnt increment is modulo 2^16.

Decomposition:
- Shared package phy_emu_pkg:
  - IDLE_CH, START_CH, TERM_CH
  - speed encodings SPD_1G, SPD_100M, SPD_10M
  - state enum {IDLE, COLLECT}
- One natural sub-module, phy_emu_byte_pace: given fmac_speed and a restart pulse, produces the byte-sample strobe. It is reusable by the transmit emulator.

Test Plan:
- 1G: FB,55×6,D5 then 8 bytes 00..07, then FD, 07s. Expected: three words, last rxd_out=64'h07070707070707FD, rxc_out=8'hFF, pkt_end=1, pkt_cnt=1.
- 100M: same packet with each byte held for 10 cycles. Expected: identical words; word_vld occurs 10× later than at 1G; samples at t+10k+5.
- 10M: same packet with each byte held for 100 cycles. Expected: identical words.
- Truncation: FB,55 then an idle character 07 at lane 2. Expected: rxd_out=64'h070707070707_55FB, rxc_out=8'hFD, pkt_err=1.
- Speed change: fmac_speed 01→10 after 3 bytes. Expected: padded word with pkt_end=pkt_err=1; the next packet is captured cleanly at 100M.
- Reset asserted mid-packet, then a full packet sent. Expected: no word_vld during reset; pkt_cnt=1 after the new packet; cap_en=0 at FB → nothing captured.
